// File: rtl/mul_pkg.sv
// Shared definitions for the shift-add multiplier: default width, the control
// strobe bundle exchanged with the control FSM, and the counter-width helper.
package mul_pkg;

  localparam int MUL_WIDTH_DEFAULT = 32;

  typedef struct packed {
    logic load;
    logic sh;
    logic ad;
  } mul_strobe_t;

  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/mul_shift_counter.sv
// Shift counter for the multiplier datapath: counts Sh pulses, flags the final
// shift (k) and, with MUL_PROTOCOL_CHECK_EN defined, detects shifts past the end.
module mul_shift_counter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
`ifdef MUL_PROTOCOL_CHECK_EN
  output logic ovr_o,
`endif
  output logic k_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      // Explicit wrap keeps non-power-of-two widths counting modulo WIDTH.
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign k_o = (cnt_q == LAST);

`ifdef MUL_PROTOCOL_CHECK_EN
  // done_q marks that the WIDTH-th shift has happened since the last clear.
  logic done_q, done_d;

  always_comb begin
    done_d = done_q;
    if (clr_i) begin
      done_d = 1'b0;
    end else if (inc_i && (cnt_q == LAST)) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign ovr_o = inc_i & done_q;
`endif

endmodule

// File: rtl/mul_datapath.sv
// Shift-add multiplier datapath driven by Load/Sh/Ad strobes from the control FSM.
// Optional protocol checker (Err output) enabled by defining MUL_PROTOCOL_CHECK_EN.
module mul_datapath
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEFAULT,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Load,
  input  logic                 Sh,
  input  logic                 Ad,
  input  logic [WIDTH-1:0]     Mcand,
  input  logic [WIDTH-1:0]     Mplier,
`ifdef MUL_PROTOCOL_CHECK_EN
  output logic                 Err,
`endif
  output logic                 M,
  output logic                 k,
  output logic [2*WIDTH-1:0]   Product
);

  mul_strobe_t strb;
  assign strb = '{load: Load, sh: Sh, ad: Ad};

  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mc_q, mc_d;
  logic [WIDTH:0]     sum;

  // Upper half plus multiplicand; bit WIDTH is the carry into ACC[2W].
  assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mc_q};

  always_comb begin
    acc_d = acc_q;
    mc_d  = mc_q;
    if (strb.load) begin
      mc_d  = Mcand;
      acc_d = {{(WIDTH+1){1'b0}}, Mplier};
    end else begin
      unique case ({strb.ad, strb.sh})
        2'b10:   acc_d = {sum, acc_q[WIDTH-1:0]};
        2'b01:   acc_d = {1'b0, acc_q[2*WIDTH:1]};
        2'b11:   acc_d = {1'b0, sum, acc_q[WIDTH-1:1]};
        default: acc_d = acc_q;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      acc_q <= '0;
      mc_q  <= '0;
    end else begin
      acc_q <= acc_d;
      mc_q  <= mc_d;
    end
  end

  logic cnt_inc;
  assign cnt_inc = strb.sh & ~strb.load;

`ifdef MUL_PROTOCOL_CHECK_EN
  logic ovr;
`endif

  mul_shift_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i (Clk),
    .rst_i (Rst),
    .clr_i (strb.load),
    .inc_i (cnt_inc),
`ifdef MUL_PROTOCOL_CHECK_EN
    .ovr_o (ovr),
`endif
    .k_o   (k)
  );

  assign M       = acc_q[0];
  assign Product = acc_q[2*WIDTH-1:0];

`ifdef MUL_PROTOCOL_CHECK_EN
  logic armed_q, armed_d;
  logic err_q, err_d;
  logic viol;

  assign viol = ((strb.ad | strb.sh) & ~armed_q) | ovr;

  always_comb begin
    armed_d = armed_q | strb.load;
    // Load clears the sticky flag unless it collides with Ad/Sh itself.
    err_d   = strb.load ? (strb.ad | strb.sh) : (err_q | viol);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      armed_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      armed_q <= armed_d;
      err_q   <= err_d;
    end
  end

  assign Err = err_q;
`endif

endmodule
